// File: rtl/traffic_light_fsm.sv
// Highway/farm-road traffic light controller driving an external phase counter.
// Latency: lamps and state are registered; clear is combinational from state, count, car and reset.
// Backpressure: none; car is a level input, and 1-cycle pulses are latched in req until served.
module traffic_light_fsm #(
    parameter int HWY_MIN  = 40,
    parameter int FARM_MAX = 20,
    parameter int FARM_MIN = 5,
    parameter int YEL_T    = 4,
    parameter int RED_T    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car,
    input  logic [6:0] count,
    output logic       clear,
    output logic [2:0] hwy,
    output logic [2:0] farm,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_HG  = 3'd0,
        S_HY  = 3'd1,
        S_AR1 = 3'd2,
        S_FG  = 3'd3,
        S_FY  = 3'd4,
        S_AR2 = 3'd5
    } state_t;

    // Lamp encodings, {R,Y,G}
    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    // Last count value of each phase, as 7-bit constants matching the counter
    localparam logic [6:0] HWY_LAST  = 7'(HWY_MIN - 1);
    localparam logic [6:0] FMAX_LAST = 7'(FARM_MAX - 1);
    localparam logic [6:0] FMIN_LAST = 7'(FARM_MIN - 1);
    localparam logic [6:0] YEL_LAST  = 7'(YEL_T - 1);
    localparam logic [6:0] RED_LAST  = 7'(RED_T - 1);

    state_t state_q, state_d;
    logic   hold_q, hold_d;
    logic   req_q, req_d;
    logic   phase_done;
    logic   hwy_min_met;
    logic   car_pending;

    // State and sticky flags; synchronous reset dominates every transition
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_HG;
            hold_q  <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            req_q   <= req_d;
        end
    end

    // hold remembers that the highway minimum has elapsed, so a counter wrap
    // during a long highway green cannot re-arm the minimum-time check.
    assign hwy_min_met = hold_q | (count == HWY_LAST);
    assign car_pending = req_q | car;

    // Next-state, phase-exit and flag update logic
    always_comb begin
        state_d    = state_q;
        phase_done = 1'b0;
        hold_d     = hold_q;
        // Sensor pulses are latched outside farm green so none is lost
        req_d      = req_q | (car & (state_q != S_FG));

        case (state_q)
            S_HG: begin
                if (hwy_min_met && car_pending) begin
                    phase_done = 1'b1;
                    state_d    = S_HY;
                    // The car that triggered this exit is the one being served
                    req_d      = 1'b0;
                end else if (count == HWY_LAST) begin
                    hold_d = 1'b1;
                end
            end
            S_HY: begin
                if (count == YEL_LAST) begin
                    phase_done = 1'b1;
                    state_d    = S_AR1;
                end
            end
            S_AR1: begin
                if (count == RED_LAST) begin
                    phase_done = 1'b1;
                    state_d    = S_FG;
                end
            end
            S_FG: begin
                // Farm green ends at its maximum, or early once the road is empty
                if ((count == FMAX_LAST) || ((count >= FMIN_LAST) && !car)) begin
                    phase_done = 1'b1;
                    state_d    = S_FY;
                end
            end
            S_FY: begin
                if (count == YEL_LAST) begin
                    phase_done = 1'b1;
                    state_d    = S_AR2;
                end
            end
            S_AR2: begin
                if (count == RED_LAST) begin
                    phase_done = 1'b1;
                    state_d    = S_HG;
                end
            end
            default: begin
                // Unused codes recover to highway green with a fresh phase
                phase_done = 1'b1;
                state_d    = S_HG;
            end
        endcase

        // hold is only meaningful while highway green persists
        if (state_d != S_HG || state_q != S_HG) begin
            hold_d = 1'b0;
        end
        // Entering or sitting in farm green serves any pending request
        if (state_d == S_FG) begin
            req_d = 1'b0;
        end
    end

    // Counter clear on every phase exit, and held while in reset
    assign clear = phase_done | ~reset;

    // Lamp decode from the registered state only, so lamps never glitch on inputs
    always_comb begin
        hwy  = LAMP_R;
        farm = LAMP_R;
        case (state_q)
            S_HG:    begin hwy = LAMP_G; farm = LAMP_R; end
            S_HY:    begin hwy = LAMP_Y; farm = LAMP_R; end
            S_AR1:   begin hwy = LAMP_R; farm = LAMP_R; end
            S_FG:    begin hwy = LAMP_R; farm = LAMP_G; end
            S_FY:    begin hwy = LAMP_R; farm = LAMP_Y; end
            S_AR2:   begin hwy = LAMP_R; farm = LAMP_R; end
            default: begin hwy = LAMP_R; farm = LAMP_R; end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
module tb_traffic_light_fsm;

    logic       clk;
    logic       reset;
    logic       car;
    logic [6:0] count;
    logic       clear;
    logic [2:0] hwy;
    logic [2:0] farm;
    logic [2:0] state;

    int checks;
    int failures;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    traffic_light_fsm #(
        .HWY_MIN (40),
        .FARM_MAX(20),
        .FARM_MIN(5),
        .YEL_T   (4),
        .RED_T   (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .car  (car),
        .count(count),
        .clear(clear),
        .hwy  (hwy),
        .farm (farm),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       car;
        logic [6:0] cnt;
        logic       clr;
        logic [2:0] st;
        logic [2:0] hwy;
        logic [2:0] farm;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic c, input logic [6:0] cnt,
                       input logic clr, input logic [2:0] st,
                       input logic [2:0] h, input logic [2:0] f);
        vec_t v;
        v.rst = rst; v.car = c; v.cnt = cnt; v.clr = clr;
        v.st = st; v.hwy = h; v.farm = f;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s at %0d: got %0d expected %0d", name, idx, got, exp);
        end
    endtask

    // Hand-derived expected state for the free-running sequence (cycle 0 = reset release)
    function automatic int exp_state(input int cyc);
        if (cyc <= 39)  return 0;
        if (cyc <= 43)  return 1;
        if (cyc <= 45)  return 2;
        if (cyc <= 65)  return 3;
        if (cyc <= 69)  return 4;
        if (cyc <= 71)  return 5;
        if (cyc <= 111) return 0;
        if (cyc <= 115) return 1;
        if (cyc <= 117) return 2;
        if (cyc <= 122) return 3;
        if (cyc <= 126) return 4;
        if (cyc <= 128) return 5;
        if (cyc <= 329) return 0;
        if (cyc <= 333) return 1;
        if (cyc <= 335) return 2;
        if (cyc <= 340) return 3;
        if (cyc <= 342) return 4;
        return 0;
    endfunction

    function automatic int exp_clear(input int cyc);
        case (cyc)
            39, 43, 45, 65, 69, 71, 111, 115, 117,
            122, 126, 128, 329, 333, 335, 340, 342: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic car_at(input int cyc);
        if (cyc == 10) return 1'b1;
        if (cyc >= 46 && cyc <= 71) return 1'b1;
        if (cyc == 329) return 1'b1;
        if (cyc == 341) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        logic clr_seen;
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        car      = 1'b0;
        count    = 7'd0;

        // Directed single-cycle vectors, count driven directly
        add(1,0, 0,  0, 0, G, R);
        add(1,0, 20, 0, 0, G, R);
        add(1,0, 39, 0, 0, G, R);
        add(1,0, 3,  0, 0, G, R);
        add(1,1, 3,  1, 0, G, R);
        add(1,0, 0,  0, 1, Y, R);
        add(1,0, 3,  1, 1, Y, R);
        add(1,0, 0,  0, 2, R, R);
        add(1,1, 1,  1, 2, R, R);
        add(1,0, 3,  0, 3, R, G);
        add(1,1, 10, 0, 3, R, G);
        add(1,1, 18, 0, 3, R, G);
        add(1,1, 19, 1, 3, R, G);
        add(1,1, 0,  0, 4, R, Y);
        add(1,0, 3,  1, 4, R, Y);
        add(1,0, 1,  1, 5, R, R);
        add(1,0, 0,  0, 0, G, R);
        add(1,0, 39, 1, 0, G, R);
        add(1,0, 0,  0, 1, Y, R);
        add(0,0, 2,  1, 1, Y, R);
        add(1,0, 39, 0, 0, G, R);
        add(1,1, 10, 1, 0, G, R);

        // Reset for two cycles
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset = 1'b0;
            #1;
            chk("reset_clear", i, clear, 1);
        end

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst;
            car   = vecs[i].car;
            count = vecs[i].cnt;
            #1;
            chk("vec_clear", i, clear, vecs[i].clr);
            chk("vec_state", i, state, vecs[i].st);
            chk("vec_hwy",   i, hwy,   vecs[i].hwy);
            chk("vec_farm",  i, farm,  vecs[i].farm);
        end

        // Multi-cycle sequence with a modelled free-running phase counter
        @(negedge clk);
        reset = 1'b0;
        car   = 1'b0;
        count = 7'd0;
        @(posedge clk);
        #1;
        count = 7'd0;
        for (int cyc = 0; cyc <= 420; cyc++) begin
            @(negedge clk);
            reset = (cyc == 342) ? 1'b0 : 1'b1;
            car   = car_at(cyc);
            #1;
            chk("seq_state", cyc, state, exp_state(cyc));
            chk("seq_clear", cyc, clear, exp_clear(cyc));
            if (cyc == 0 || cyc == 343) begin
                chk("seq_hwy",   cyc, hwy,   G);
                chk("seq_farm",  cyc, farm,  R);
                chk("seq_count", cyc, count, 0);
            end
            if (cyc == 46) begin
                chk("seq_fg_hwy",  cyc, hwy,  R);
                chk("seq_fg_farm", cyc, farm, G);
            end
            if (cyc == 330) chk("seq_wrap_hy_hwy", cyc, hwy, Y);
            clr_seen = clear;
            @(posedge clk);
            #1;
            count = clr_seen ? 7'd0 : count + 7'd1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
